// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache memory arbiter.
// State encoding, owner encoding and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// slave: the arbiter; master: caches plus memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) ();

  logic               i_read;
  logic [ADDR_W-1:0]  i_address;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;

  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between I and D requesters.
// On a tie the requester that was not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    grant = OWNER_I;
    valid = req_i | req_d;
    unique case (1'b1)
      (req_i && req_d):
        grant = (last == OWNER_D) ? OWNER_I : OWNER_D;
      (req_d && !req_i):
        grant = OWNER_D;
      default:
        grant = OWNER_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads and D-cache reads/write-backs
// onto one block memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t state_q, state_n;
  owner_t owner_q, owner_n;
  owner_t last_q, last_n;
  logic   seen_q, seen_n;
  logic   i_done_q, i_done_n;
  logic   d_done_q, d_done_n;
  logic   rd_q, rd_n;
  logic   wr_q, wr_n;

  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [BLOCK_W-1:0] wdata_q, wdata_n;
  logic [BLOCK_W-1:0] irdata_q, irdata_n;
  logic [BLOCK_W-1:0] drdata_q, drdata_n;

  owner_t pick;
  logic   pick_v;

  arb_rr2 u_rr (
    .req_i (bus.i_read),
    .req_d (bus.d_read | bus.d_write),
    .last  (last_q),
    .grant (pick),
    .valid (pick_v)
  );

  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    last_n   = last_q;
    seen_n   = seen_q;
    i_done_n = i_done_q;
    d_done_n = d_done_q;
    rd_n     = rd_q;
    wr_n     = wr_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    irdata_n = irdata_q;
    drdata_n = drdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          owner_n = pick;
          last_n  = pick;
          seen_n  = 1'b0;
          if (pick == OWNER_I) begin
            state_n = GRANT_I;
            addr_n  = bus.i_address;
            rd_n    = 1'b1;
            wr_n    = 1'b0;
          end else begin
            state_n = GRANT_D;
            addr_n  = bus.d_address;
            wdata_n = bus.d_writedata;
            // a simultaneous read+write is a write-back
            wr_n    = bus.d_write;
            rd_n    = ~bus.d_write;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_busywait) begin
          seen_n = 1'b1;
        end else if (seen_q) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = RELEASE;
          if (owner_q == OWNER_I) begin
            irdata_n = bus.mem_readdata;
            i_done_n = 1'b1;
          end else begin
            d_done_n = 1'b1;
            if (rd_q) drdata_n = bus.mem_readdata;
          end
        end
      end
      RELEASE: begin
        i_done_n = 1'b0;
        d_done_n = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_I;
      last_q   <= OWNER_D;
      seen_q   <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      last_q   <= last_n;
      seen_q   <= seen_n;
      i_done_q <= i_done_n;
      d_done_q <= d_done_n;
      rd_q     <= rd_n;
      wr_q     <= wr_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      irdata_q <= irdata_n;
      drdata_q <= drdata_n;
    end
  end

  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.i_readdata    = irdata_q;
  assign bus.d_readdata    = drdata_q;
  assign bus.i_busywait    = bus.i_read & ~i_done_q;
  assign bus.d_busywait    = (bus.d_read | bus.d_write) & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency
// block memory model.
module tb_mem_arbiter;

  localparam int LAT = 5;

  localparam logic [127:0] D_A5  = {16{8'hA5}};
  localparam logic [127:0] D_WR  = {8{16'h1234}};
  localparam logic [127:0] D_I10 = {4{32'h1010_0001}};
  localparam logic [127:0] D_D20 = {4{32'h2020_0002}};
  localparam logic [127:0] D_I12 = {4{32'h1212_0012}};
  localparam logic [127:0] D_I11 = {4{32'h1111_0011}};
  localparam logic [127:0] D_D21 = {4{32'h2121_0021}};
  localparam logic [127:0] D_W2A = {4{32'hCAFE_002A}};
  localparam logic [127:0] D_D31 = {4{32'h3131_0031}};
  localparam logic [127:0] D_I06 = {4{32'h0606_0006}};
  localparam logic [127:0] D_I07 = {4{32'h0707_0007}};

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(6), .BLOCK_W(128)) bus ();

  mem_arbiter #(.ADDR_W(6), .BLOCK_W(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] pat(input logic [5:0] a);
    case (a)
      6'h05:   return D_A5;
      6'h10:   return D_I10;
      6'h20:   return D_D20;
      6'h12:   return D_I12;
      6'h11:   return D_I11;
      6'h21:   return D_D21;
      6'h31:   return D_D31;
      6'h06:   return D_I06;
      6'h07:   return D_I07;
      default: return 128'h0;
    endcase
  endfunction

  logic         mbusy    = 1'b0;
  logic         wait_low = 1'b0;
  int           cnt      = 0;
  logic [127:0] rdata    = '0;
  logic [5:0]   wr_addr  = '0;
  logic [127:0] wr_data  = '0;

  // busy one cycle after strobe, LAT cycles long, then
  // waits for the strobe to drop before accepting another
  always @(posedge clock) begin
    if (mbusy) begin
      if (cnt == 1) begin
        mbusy    <= 1'b0;
        wait_low <= 1'b1;
        if (bus.mem_write) begin
          wr_addr <= bus.mem_address;
          wr_data <= bus.mem_writedata;
        end else begin
          rdata <= pat(bus.mem_address);
        end
      end
      cnt <= cnt - 1;
    end else if (wait_low) begin
      if (!bus.mem_read && !bus.mem_write) wait_low <= 1'b0;
    end else if (bus.mem_read || bus.mem_write) begin
      mbusy <= 1'b1;
      cnt   <= LAT;
    end
  end

  assign bus.mem_busywait = mbusy;
  assign bus.mem_readdata = rdata;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input bit is_d,
                            input string tag,
                            output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((is_d ? bus.d_busywait : bus.i_busywait) && n < 40);
    chk(tag, 128'(is_d ? bus.d_busywait : bus.i_busywait), '0);
  endtask

  initial begin
    int  n;
    bit  ok;
    bus.i_read      = 1'b0;
    bus.i_address   = '0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_address   = '0;
    bus.d_writedata = '0;

    repeat (3) @(negedge clock);
    chk("rst_mem_read", 128'(bus.mem_read), 0);
    chk("rst_mem_write", 128'(bus.mem_write), 0);
    chk("rst_mem_addr", 128'(bus.mem_address), 0);
    chk("rst_mem_wdata", bus.mem_writedata, 0);
    chk("rst_i_rdata", bus.i_readdata, 0);
    chk("rst_d_rdata", bus.d_readdata, 0);
    reset = 1'b1;
    @(negedge clock);

    // single I read, latency check
    bus.i_read    = 1'b1;
    bus.i_address = 6'h05;
    #1 chk("i1_busy_comb", 128'(bus.i_busywait), 1);
    @(negedge clock);
    chk("i1_mem_read", 128'(bus.mem_read), 1);
    chk("i1_mem_addr", 128'(bus.mem_address), 128'h05);
    wait_ready(1'b0, "i1_timeout", n);
    chk("i1_latency", 128'(n), 7);
    chk("i1_rdata", bus.i_readdata, D_A5);
    chk("i1_d_busy", 128'(bus.d_busywait), 0);
    chk("i1_strobe_off", 128'(bus.mem_read), 0);
    bus.i_read = 1'b0;
    @(negedge clock);
    chk("i1_rdata_hold", bus.i_readdata, D_A5);

    // D write-back
    bus.d_write     = 1'b1;
    bus.d_address   = 6'h3F;
    bus.d_writedata = D_WR;
    @(negedge clock);
    chk("dw_mem_write", 128'(bus.mem_write), 1);
    chk("dw_no_read", 128'(bus.mem_read), 0);
    chk("dw_addr", 128'(bus.mem_address), 128'h3F);
    chk("dw_wdata", bus.mem_writedata, D_WR);
    wait_ready(1'b1, "dw_timeout", n);
    chk("dw_d_rdata", bus.d_readdata, 0);
    chk("dw_mem_got", wr_data, D_WR);
    bus.d_write = 1'b0;
    @(negedge clock);

    // tie after reset: I first, then D
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.i_read    = 1'b1;
    bus.i_address = 6'h10;
    bus.d_read    = 1'b1;
    bus.d_address = 6'h20;
    @(negedge clock);
    chk("t1_first_addr", 128'(bus.mem_address), 128'h10);
    wait_ready(1'b0, "t1_i_timeout", n);
    chk("t1_i_rdata", bus.i_readdata, D_I10);
    chk("t1_d_still_busy", 128'(bus.d_busywait), 1);
    bus.i_read = 1'b0;
    @(negedge clock);
    chk("t1_gap", 128'(bus.mem_read), 0);
    @(negedge clock);
    chk("t1_d_read", 128'(bus.mem_read), 1);
    chk("t1_d_addr", 128'(bus.mem_address), 128'h20);
    wait_ready(1'b1, "t1_d_timeout", n);
    chk("t1_d_rdata", bus.d_readdata, D_D20);
    bus.d_read = 1'b0;
    @(negedge clock);

    // I alone, so that I is the last grant
    bus.i_read    = 1'b1;
    bus.i_address = 6'h12;
    wait_ready(1'b0, "i2_timeout", n);
    chk("i2_rdata", bus.i_readdata, D_I12);
    bus.i_read = 1'b0;
    @(negedge clock);

    // tie with last=I: D first
    bus.i_read    = 1'b1;
    bus.i_address = 6'h11;
    bus.d_read    = 1'b1;
    bus.d_address = 6'h21;
    @(negedge clock);
    chk("t2_first_addr", 128'(bus.mem_address), 128'h21);
    wait_ready(1'b1, "t2_d_timeout", n);
    chk("t2_d_rdata", bus.d_readdata, D_D21);
    chk("t2_i_still_busy", 128'(bus.i_busywait), 1);
    bus.d_read = 1'b0;
    wait_ready(1'b0, "t2_i_timeout", n);
    chk("t2_i_rdata", bus.i_readdata, D_I11);
    bus.i_read = 1'b0;
    @(negedge clock);

    // read and write together behave as a write
    bus.d_read      = 1'b1;
    bus.d_write     = 1'b1;
    bus.d_address   = 6'h2A;
    bus.d_writedata = D_W2A;
    @(negedge clock);
    chk("rw_mem_write", 128'(bus.mem_write), 1);
    chk("rw_no_read", 128'(bus.mem_read), 0);
    wait_ready(1'b1, "rw_timeout", n);
    chk("rw_d_rdata_kept", bus.d_readdata, D_D21);
    chk("rw_mem_addr", 128'(wr_addr), 128'h2A);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    @(negedge clock);

    // reset in the middle of a D read
    bus.d_read    = 1'b1;
    bus.d_address = 6'h30;
    repeat (3) @(negedge clock);
    chk("mr_busy_before", 128'(bus.mem_busywait), 1);
    reset = 1'b0;
    @(negedge clock);
    chk("mr_mem_read", 128'(bus.mem_read), 0);
    chk("mr_mem_addr", 128'(bus.mem_address), 0);
    chk("mr_d_rdata", bus.d_readdata, 0);
    chk("mr_i_rdata", bus.i_readdata, 0);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!bus.d_busywait) ok = 1'b0;
      @(negedge clock);
    end
    chk("mr_no_done", 128'(ok), 1);
    bus.d_address = 6'h31;
    reset = 1'b1;
    wait_ready(1'b1, "mr_timeout", n);
    chk("mr_fresh_rdata", bus.d_readdata, D_D31);
    bus.d_read = 1'b0;
    @(negedge clock);

    // back-to-back I reads
    bus.i_read    = 1'b1;
    bus.i_address = 6'h06;
    wait_ready(1'b0, "bb1_timeout", n);
    chk("bb1_rdata", bus.i_readdata, D_I06);
    bus.i_read = 1'b0;
    @(negedge clock);
    chk("bb_gap", 128'(bus.mem_read), 0);
    bus.i_read    = 1'b1;
    bus.i_address = 6'h07;
    @(negedge clock);
    chk("bb2_mem_read", 128'(bus.mem_read), 1);
    chk("bb2_addr", 128'(bus.mem_address), 128'h07);
    chk("bb_hold", bus.i_readdata, D_I06);
    wait_ready(1'b0, "bb2_timeout", n);
    chk("bb2_rdata", bus.i_readdata, D_I07);
    bus.i_read = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one unified block memory between the instruction cache and the data cache of the simple processor. Accepts block-read requests from the instruction cache and block read/write requests from the data cache, serialises them onto a single memory port, and returns per-requester busywait and block data. It sits between both caches and main memory, replacing the separate instruction and data memories.

## Interface
- ADDR_W, 6, block address width (one address per 16-byte block)
- BLOCK_W, 128, block data width in bits
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- i_read  input  1  instruction-cache block read request, level, held until i_busywait low
- i_address  input  ADDR_W  instruction-cache block address
- i_readdata  output  BLOCK_W  block returned to instruction cache, registered
- i_busywait  output  1  instruction-cache stall
- d_read  input  1  data-cache block read request, level
- d_write  input  1  data-cache block write-back request, level
- d_address  input  ADDR_W  data-cache block address
- d_writedata  input  BLOCK_W  data-cache write-back block
- d_readdata  output  BLOCK_W  block returned to data cache, registered
- d_busywait  output  1  data-cache stall
- mem_read, mem_write  output  1 each  memory strobes, registered
- mem_address  output  ADDR_W  memory block address, registered
- mem_writedata  output  BLOCK_W  memory write block, registered
- mem_readdata  input  BLOCK_W  memory read block
- mem_busywait  input  1  memory busy

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Registers: state, owner (I/D), last (last granted), seen_busy, i_done, d_done.
- IDLE: only i pending -> GRANT_I; only d pending (d_read|d_write) -> GRANT_D; both -> the one not equal to last (round-robin); none -> stay.
- On entering GRANT_x: drive mem_address/mem_writedata from requester; mem_read=1 for I or D-read; mem_write=1 for D-write; d_write and d_read both high -> treated as write. last <= x; seen_busy <= 0.
- GRANT_x: seen_busy <= 1 when mem_busywait=1. When seen_busy=1 and mem_busywait=0: latch mem_readdata into i_readdata (I) or d_readdata (D-read; D-write leaves d_readdata unchanged), clear strobes, set x_done=1, go RELEASE.
- RELEASE: one cycle; requests ignored; x_done cleared at exit; -> IDLE.
- i_busywait = i_read & ~i_done (combinational); d_busywait = (d_read|d_write) & ~d_done. Requester drops its request at the edge ending RELEASE.
- Requester inputs are captured only on GRANT entry; changes during a grant are ignored.
- Readdata outputs hold last returned block until next completion for that requester.

## Timing
- Reset (reset=0 at an edge): state=IDLE, all strobes 0, mem_address 0, mem_writedata 0, i_readdata/d_readdata 0, i_done/d_done 0, seen_busy 0, last=D (so I wins first tie). Applies mid-grant: transaction abandoned, no done pulse.
- Request sampled at edge E0 -> strobe high after E0. Memory must raise mem_busywait within one cycle. Completion edge Ec = first edge with seen_busy=1 and mem_busywait=0; x_done and readdata valid after Ec for exactly one cycle (RELEASE); IDLE after Ec+1; next grant earliest after Ec+2.
- Memory sees strobe low for at least one cycle between transactions.
- Loser of a tie keeps busywait high throughout; starvation bound: one foreign transaction.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, GRANT_I, GRANT_D, RELEASE), owner encoding (OWNER_I=0, OWNER_D=1), ADDR_W/BLOCK_W defaults.
- One sub-module natural: arb_rr2, combinational 2-way round-robin pick (inputs req_i, req_d, last; output grant, valid).

## Test plan
- I read only, addr 6'h05, memory busy 5 cycles returning 128'hA5..: mem_read high one cycle after request, i_readdata=128'hA5.. with i_busywait low one cycle after completion, d_busywait stays 0.
- D write addr 6'h3F, data 128'h1234..: mem_write=1, mem_writedata matches, d_readdata unchanged, no mem_read.
- I and D read raised same cycle after reset: I granted first, D granted after I's RELEASE; second simultaneous pair -> D first.
- d_read and d_write both high: memory sees write only.
- reset=0 during GRANT_D with memory busy: all outputs 0 next cycle, no d_done pulse, fresh request then completes normally.
- Back-to-back I requests: memory strobe low for at least one cycle between them; i_readdata holds first block until second completes.
